// File: rtl/arm_cortex_m0_mul_sequencer.sv
// Shift-add MULS sequencer that borrows the shared Cortex-M0 ALU for one add per multiplier bit.
// Define MUL_EARLY_EXIT_EN to end the iteration once the remaining multiplier bits are all zero.
module arm_cortex_m0_mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             neg,
  output logic             zero,
  output logic [WIDTH-1:0] alu_operand_A,
  output logic [WIDTH-1:0] alu_operand_B,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_neg,
  input  logic             alu_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b111;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FLAGS = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    neg_d     = neg_q;
    zero_d    = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        // With early exit, an all-zero remaining multiplier leaves acc untouched.
        if (EARLY_EXIT && (mplier_q == '0)) begin
          state_d = S_FLAGS;
        end else begin
          acc_d    = alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == LAST_STEP) begin
            state_d = S_FLAGS;
          end
        end
      end
      S_FLAGS: begin
        product_d = alu_result;
        neg_d     = alu_neg;
        zero_d    = alu_zero;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
    end
  end

  // ALU-side drive depends on registered state only, never on alu_result.
  always_comb begin
    alu_control   = ALU_AND;
    alu_operand_A = '0;
    alu_operand_B = '0;
    case (state_q)
      S_ITER: begin
        alu_control   = ALU_ADD;
        alu_operand_A = acc_q;
        alu_operand_B = mplier_q[0] ? mcand_q : '0;
      end
      S_FLAGS: begin
        alu_control   = ALU_PASSB;
        alu_operand_B = acc_q;
      end
      default: begin
        alu_control = ALU_AND;
      end
    endcase
  end

  assign busy    = (state_q == S_ITER) || (state_q == S_FLAGS);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign neg     = neg_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_arm_cortex_m0_mul_sequencer.sv
// Bench for arm_cortex_m0_mul_sequencer: behavioural ALU, table vectors, random products, abort/re-pulse sequences.
module tb_arm_cortex_m0_mul_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        neg;
  logic        zero;
  logic [31:0] alu_operand_A;
  logic [31:0] alu_operand_B;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_neg;
  logic        alu_zero;

  int checks;
  int errors;

  arm_cortex_m0_mul_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .neg          (neg),
    .zero         (zero),
    .alu_operand_A(alu_operand_A),
    .alu_operand_B(alu_operand_B),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_neg      (alu_neg),
    .alu_zero     (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU as seen by the sequencer
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_operand_A & alu_operand_B;
      3'b011:  alu_result = alu_operand_A + alu_operand_B;
      3'b111:  alu_result = alu_operand_B;
      default: alu_result = '0;
    endcase
    alu_neg  = alu_result[31];
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        n;
    logic        z;
    bit          repulse;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return (n == 32) ? 34 : 3 + n;
`else
    return 34;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ep,
                         input logic en, input logic ez, input bit repulse);
    int lat;
    logic [31:0] mask;
    lat = exp_latency(b);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    next_cycle();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    for (int c = 1; c <= lat; c++) begin
      if (repulse && c == 5) start = 1'b1;
      if (repulse && c == 6) start = 1'b0;
      if (repulse && c == lat) start = 1'b1;
      if (c <= lat - 2) begin
        mask = (32'h1 << (c - 1)) - 32'h1;
        check("iter_ctrl", {29'd0, alu_control}, 32'h3);
        check("iter_opA", alu_operand_A, a * (b & mask));
        check("iter_opB", alu_operand_B, b[c-1] ? (a << (c - 1)) : 32'h0);
        check("iter_busy", {31'd0, busy}, 32'h1);
        check("iter_done", {31'd0, done}, 32'h0);
      end else if (c == lat - 1) begin
        check("flags_ctrl", {29'd0, alu_control}, 32'h7);
        check("flags_opA", alu_operand_A, 32'h0);
        check("flags_opB", alu_operand_B, ep);
        check("flags_busy", {31'd0, busy}, 32'h1);
        check("flags_done", {31'd0, done}, 32'h0);
      end else begin
        check("done_pulse", {31'd0, done}, 32'h1);
        check("done_busy", {31'd0, busy}, 32'h0);
        check("done_ctrl", {29'd0, alu_control}, 32'h0);
        check("done_opA", alu_operand_A, 32'h0);
        check("done_opB", alu_operand_B, 32'h0);
        check("product", product, ep);
        check("neg", {31'd0, neg}, {31'd0, en});
        check("zero", {31'd0, zero}, {31'd0, ez});
      end
      if (c < lat) next_cycle();
    end
    next_cycle();
    start = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'h0);
    check("idle_done", {31'd0, done}, 32'h0);
    check("idle_ctrl", {29'd0, alu_control}, 32'h0);
    next_cycle();
    check("idle2_busy", {31'd0, busy}, 32'h0);
    check("idle2_done", {31'd0, done}, 32'h0);
    check("product_held", product, ep);
  endtask

  task automatic run_abort();
    start = 1'b1;
    multiplicand = 32'h0000_1234;
    multiplier = 32'hFFFF_0001;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 10; c++) next_cycle();
    #3 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_done", {31'd0, done}, 32'h0);
    check("abort_product", product, 32'h0);
    check("abort_neg", {31'd0, neg}, 32'h0);
    check("abort_zero", {31'd0, zero}, 32'h1);
    check("abort_ctrl", {29'd0, alu_control}, 32'h0);
    #1 reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      check("post_abort_done", {31'd0, done}, 32'h0);
      check("post_abort_busy", {31'd0, busy}, 32'h0);
    end
    check("post_abort_product", product, 32'h0);
    check("post_abort_zero", {31'd0, zero}, 32'h1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rp;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;

    vecs[0] = '{32'd7,         32'd6,         32'd42,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h00010000,  32'h00010000,  32'h00000000,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h40000000,  32'd2,         32'h80000000,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'd0,         32'h12345678,  32'h00000000,  1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'd3,         32'hFFFFFFFB,  32'hFFFFFFF1,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF,  32'd2,         32'hFFFFFFFE,  1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'd1000,      32'd1000,      32'd1000000,   1'b0, 1'b0, 1'b1};

    #12 reset = 1'b0;
    next_cycle();
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    check("rst_product", product, 32'h0);
    check("rst_neg", {31'd0, neg}, 32'h0);
    check("rst_zero", {31'd0, zero}, 32'h1);
    check("rst_ctrl", {29'd0, alu_control}, 32'h0);
    check("rst_opA", alu_operand_A, 32'h0);
    check("rst_opB", alu_operand_B, 32'h0);

    for (int i = 0; i < 8; i++)
      run_mul(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].n, vecs[i].z, vecs[i].repulse);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 1) rb = rb >> $urandom_range(31, 0);
      if (i % 7 == 3) ra = ra & 32'h0000_00FF;
      rp = ra * rb;
      run_mul(ra, rb, rp, rp[31], rp == 32'h0, (i % 4) == 0);
    end

    run_abort();
    run_mul(32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
